// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: ALU control decode, JR detect and an iterative
// MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO registers.
// Optional macro MULDIV_DIV_EN: when defined, the restoring divider is built
// and DIV/DIVU issue; when undefined, only MULT/MULTU issue.
module alu_muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [1:0]       ALUOp,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [3:0]       ALUCtrl,
   output logic             Jr,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] mf_data
);
   localparam int            CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [5:0]    F_MULT   = 6'b011000;
   localparam logic [5:0]    F_MULTU  = 6'b011001;
   localparam logic [5:0]    F_MFHI   = 6'b010000;
   localparam logic [5:0]    F_MFLO   = 6'b010010;
   localparam logic [5:0]    F_JR     = 6'b001000;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   state_t state, state_next;

   logic               is_md, issue, last;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   a_reg, b_reg, a_mag, b_mag;
   logic               signed_reg, neg_a, neg_b;
   // work holds the running partial product, or remainder:quotient for divide
   logic [2*WIDTH-1:0] work, work_step, work_mul, prod_fix;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   res_hi, res_lo;

   // Combinational ALU control decode; independent of reset and FSM state
   always_comb begin
      ALUCtrl = 4'b0010;
      case (ALUOp)
         2'b01: ALUCtrl = 4'b0110;
         2'b10: begin
            case (funct)
               6'b100000, 6'b100001: ALUCtrl = 4'b0010;
               6'b100010, 6'b100011: ALUCtrl = 4'b0110;
               6'b100100:            ALUCtrl = 4'b0000;
               6'b100101:            ALUCtrl = 4'b0001;
               6'b100110:            ALUCtrl = 4'b0011;
               6'b100111:            ALUCtrl = 4'b1100;
               6'b101010:            ALUCtrl = 4'b0111;
               6'b000000:            ALUCtrl = 4'b1000;
               6'b000010:            ALUCtrl = 4'b1001;
               6'b000011:            ALUCtrl = 4'b1010;
               default:              ALUCtrl = 4'b0010;
            endcase
         end
         default: ALUCtrl = 4'b0010;
      endcase
   end

   assign Jr = (ALUOp == 2'b10) && (funct == F_JR);

   // MFHI/MFLO read path; old HI/LO stay visible while an operation runs
   always_comb begin
      mf_data = '0;
      if (ALUOp == 2'b10 && funct == F_MFHI) mf_data = hi;
      else if (ALUOp == 2'b10 && funct == F_MFLO) mf_data = lo;
   end

   // Sign-magnitude view of the captured operands
   assign neg_a = signed_reg & a_reg[WIDTH-1];
   assign neg_b = signed_reg & b_reg[WIDTH-1];
   assign a_mag = neg_a ? -a_reg : a_reg;
   assign b_mag = neg_b ? -b_reg : b_reg;
   assign last  = (cnt == LAST_CNT);

   // Shift-add step: multiplier bit cnt of |a| selects whether |b| is added
   assign mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} +
                     {1'b0, (a_mag[cnt[CW-2:0]] ? b_mag : {WIDTH{1'b0}})};
   assign work_mul = {mul_sum, work[WIDTH-1:1]};
   assign prod_fix = (neg_a ^ neg_b) ? -work_mul : work_mul;

`ifdef MULDIV_DIV_EN
   localparam logic [5:0]    F_DIV    = 6'b011010;
   localparam logic [5:0]    F_DIVU   = 6'b011011;
   localparam logic [CW-2:0] LAST_IDX = (CW-1)'(WIDTH - 1);

   logic               div_reg;
   logic [CW-2:0]      div_idx;
   logic [WIDTH:0]     div_shift, div_diff;
   logic [2*WIDTH-1:0] work_div;

   assign is_md = (funct == F_MULT) || (funct == F_MULTU) ||
                  (funct == F_DIV)  || (funct == F_DIVU);

   // Restoring step: bring in the next dividend bit (MSB first), trial subtract
   assign div_idx   = LAST_IDX - cnt[CW-2:0];
   assign div_shift = {work[2*WIDTH-1:WIDTH], a_mag[div_idx]};
   assign div_diff  = div_shift - {1'b0, b_mag};
   assign work_div  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0],  work[WIDTH-2:0], 1'b1};
   assign work_step = div_reg ? work_div : work_mul;

   // Final HI/LO values with sign fix-up and the divide-by-zero convention
   always_comb begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
      if (div_reg) begin
         if (b_reg == '0) begin
            res_hi = a_reg;
            res_lo = '1;
         end else begin
            res_lo = (neg_a ^ neg_b) ? -work_div[WIDTH-1:0] : work_div[WIDTH-1:0];
            res_hi = neg_a ? -work_div[2*WIDTH-1:WIDTH] : work_div[2*WIDTH-1:WIDTH];
         end
      end
   end

   // Remember whether the captured operation is a divide
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        div_reg <= 1'b0;
      else if (issue) div_reg <= funct[1];
   end
`else
   assign is_md     = (funct == F_MULT) || (funct == F_MULTU);
   assign work_step = work_mul;

   // Final HI/LO values: product halves after sign fix-up
   always_comb begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
   end
`endif

   assign issue = valid && (ALUOp == 2'b10) && is_md && (state == IDLE);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // FSM next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (issue) state_next = BUSY;
         BUSY:    if (last)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: hold the pipeline from the issue cycle through the last BUSY cycle
   always_comb begin
      stall = 1'b0;
      if (!rst && (state == BUSY || issue)) stall = 1'b1;
   end

   // Operand capture on issue, then one iteration per BUSY cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         signed_reg <= 1'b0;
         work       <= '0;
      end else if (issue) begin
         cnt        <= '0;
         a_reg      <= src_a;
         b_reg      <= src_b;
         signed_reg <= ~funct[0];
         work       <= '0;
      end else if (state == BUSY) begin
         cnt        <= cnt + CW'(1);
         work       <= work_step;
      end
   end

   // HI/LO written only on the edge that ends the last BUSY cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (state == BUSY && last) begin
         hi <= res_hi;
         lo <= res_lo;
      end
   end
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb_alu_muldiv_ctrl: self-checking bench for alu_muldiv_ctrl (WIDTH=32).
// Honours MULDIV_DIV_EN the same way as the design.
module tb_alu_muldiv_ctrl;
   localparam int W = 32;
   localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO  = 6'b010010;

   logic         clk = 1'b0;
   logic         rst, valid;
   logic [1:0]   ALUOp;
   logic [5:0]   funct;
   logic [W-1:0] src_a, src_b;
   logic [3:0]   ALUCtrl;
   logic         Jr, stall;
   logic [W-1:0] hi, lo, mf_data;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0;

   alu_muldiv_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .valid(valid), .ALUOp(ALUOp), .funct(funct),
      .src_a(src_a), .src_b(src_b), .ALUCtrl(ALUCtrl), .Jr(Jr),
      .stall(stall), .hi(hi), .lo(lo), .mf_data(mf_data)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   // Reference: architectural result of one mul/div instruction
   function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl);
      longint     p;
      logic [63:0] up;
      int         sa, sb;
      sa = a;
      sb = b;
      rh = m_hi;
      rl = m_lo;
      if (f == F_MULT) begin
         p  = longint'(sa) * longint'(sb);
         rh = p[63:32];
         rl = p[31:0];
      end else if (f == F_MULTU) begin
         up = {32'h0, a} * {32'h0, b};
         rh = up[63:32];
         rl = up[31:0];
      end else if (f == F_DIV) begin
         if (b == 32'h0) begin
            rh = a; rl = 32'hFFFF_FFFF;
         end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            rh = 32'h0; rl = 32'h8000_0000;
         end else begin
            rl = sa / sb; rh = sa % sb;
         end
      end else if (f == F_DIVU) begin
         if (b == 32'h0) begin
            rh = a; rl = 32'hFFFF_FFFF;
         end else begin
            rl = a / b; rh = a % b;
         end
      end
   endfunction

   // Issue one mul/div, hold it while stalled, check latency, results and no re-issue
   task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eh, el;
      int n;
      bit moved;
      ref_op(f, a, b, eh, el);
      next_cycle();
      valid = 1'b1; ALUOp = 2'b10; funct = f; src_a = a; src_b = b;
      #1;
      n = 0;
      moved = 1'b0;
      while (stall === 1'b1 && n < 100) begin
         if (hi !== m_hi || lo !== m_lo) moved = 1'b1;
         n++;
         @(posedge clk);
         #3;
      end
      checks++;
      if (n !== 33) begin errors++; $display("FAIL %s stall_cycles got=%0d exp=33", name, n); end
      checks++;
      if (moved) begin errors++; $display("FAIL %s hilo_changed_while_busy got=1 exp=0", name); end
      checks++;
      if (hi !== eh) begin errors++; $display("FAIL %s hi got=%h exp=%h", name, hi, eh); end
      checks++;
      if (lo !== el) begin errors++; $display("FAIL %s lo got=%h exp=%h", name, lo, el); end
      m_hi = eh;
      m_lo = el;
      // held instruction was still valid in DONE; the following cycle must not be busy
      next_cycle();
      valid = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL %s reissue_stall got=%b exp=0", name, stall); end
      $display("op %s a=%h b=%h -> hi=%h lo=%h stall_cycles=%0d", name, a, b, hi, lo, n);
   endtask

   task automatic test_reset();
      rst = 1'b1; valid = 1'b1; ALUOp = 2'b10; funct = F_MULT; src_a = 32'd7; src_b = 32'd9;
      #3;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++;
      if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
      funct = F_MFHI;
      #1;
      checks++;
      if (mf_data !== 32'h0) begin errors++; $display("FAIL reset_mfhi got=%h exp=0", mf_data); end
      ALUOp = 2'b01;
      #1;
      checks++;
      if (ALUCtrl !== 4'b0110) begin errors++; $display("FAIL reset_aluctrl got=%b exp=0110", ALUCtrl); end
      $display("reset: stall=%b hi=%h lo=%h", stall, hi, lo);
      valid = 1'b0; ALUOp = 2'b00; funct = 6'h0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_decode();
      logic [12:0] tbl [18];
      logic [1:0]  op;
      logic [5:0]  f;
      logic [3:0]  ec;
      logic        ej;
      tbl = '{ {2'b00, 6'b100010, 4'b0010, 1'b0}, {2'b11, 6'b100010, 4'b0010, 1'b0},
               {2'b01, 6'b100000, 4'b0110, 1'b0}, {2'b10, 6'b100000, 4'b0010, 1'b0},
               {2'b10, 6'b100001, 4'b0010, 1'b0}, {2'b10, 6'b100010, 4'b0110, 1'b0},
               {2'b10, 6'b100011, 4'b0110, 1'b0}, {2'b10, 6'b100100, 4'b0000, 1'b0},
               {2'b10, 6'b100101, 4'b0001, 1'b0}, {2'b10, 6'b100110, 4'b0011, 1'b0},
               {2'b10, 6'b100111, 4'b1100, 1'b0}, {2'b10, 6'b101010, 4'b0111, 1'b0},
               {2'b10, 6'b000000, 4'b1000, 1'b0}, {2'b10, 6'b000010, 4'b1001, 1'b0},
               {2'b10, 6'b000011, 4'b1010, 1'b0}, {2'b10, 6'b001000, 4'b0010, 1'b1},
               {2'b10, 6'b111111, 4'b0010, 1'b0}, {2'b01, 6'b001000, 4'b0110, 1'b0} };
      valid = 1'b0;
      for (int i = 0; i < 18; i++) begin
         {op, f, ec, ej} = tbl[i];
         ALUOp = op; funct = f;
         #1;
         checks++;
         if (ALUCtrl !== ec) begin errors++; $display("FAIL decode_ctrl op=%b f=%b got=%b exp=%b", op, f, ALUCtrl, ec); end
         checks++;
         if (Jr !== ej) begin errors++; $display("FAIL decode_jr op=%b f=%b got=%b exp=%b", op, f, Jr, ej); end
         $display("decode op=%b funct=%b -> ALUCtrl=%b Jr=%b", op, f, ALUCtrl, Jr);
      end
   endtask

   task automatic test_mf();
      next_cycle();
      valid = 1'b1; ALUOp = 2'b10;
      funct = F_MFHI; #1;
      checks++;
      if (mf_data !== m_hi) begin errors++; $display("FAIL mfhi got=%h exp=%h", mf_data, m_hi); end
      funct = F_MFLO; #1;
      checks++;
      if (mf_data !== m_lo) begin errors++; $display("FAIL mflo got=%h exp=%h", mf_data, m_lo); end
      funct = 6'b100000; #1;
      checks++;
      if (mf_data !== 32'h0) begin errors++; $display("FAIL mf_other got=%h exp=0", mf_data); end
      $display("mf: hi=%h lo=%h", m_hi, m_lo);
      valid = 1'b0;
   endtask

   task automatic test_mul_vectors();
      run_op("MULTU_ffffffff_x_2", F_MULTU, 32'hFFFF_FFFF, 32'h2);
      run_op("MULT_m3_x_5", F_MULT, 32'hFFFF_FFFD, 32'd5);
      run_op("MULT_min_x_min", F_MULT, 32'h8000_0000, 32'h8000_0000);
   endtask

`ifdef MULDIV_DIV_EN
   task automatic test_div();
      run_op("DIV_m7_by_2", F_DIV, 32'hFFFF_FFF9, 32'd2);
      run_op("DIVU_5_by_0", F_DIVU, 32'd5, 32'd0);
      run_op("DIV_min_by_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("DIV_m8_by_0", F_DIV, 32'hFFFF_FFF8, 32'd0);
      run_op("DIVU_big", F_DIVU, 32'hFFFF_FFF0, 32'd7);
   endtask
`else
   task automatic test_div();
      int hi_n;
      next_cycle();
      valid = 1'b1; ALUOp = 2'b10; funct = F_DIV; src_a = 32'd8; src_b = 32'd2;
      hi_n = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (stall !== 1'b0) hi_n++;
         next_cycle();
      end
      checks++;
      if (hi_n !== 0) begin errors++; $display("FAIL div_disabled_stall got=%0d exp=0", hi_n); end
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL div_disabled_hilo got=%h/%h exp=%h/%h", hi, lo, m_hi, m_lo); end
      $display("div disabled: DIV 8/2 stall_cycles=%0d hi=%h lo=%h", hi_n, hi, lo);
      valid = 1'b0;
   endtask
`endif

   task automatic test_reset_busy();
      next_cycle();
      valid = 1'b1; ALUOp = 2'b10; funct = F_MULTU; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
      for (int i = 0; i < 10; i++) next_cycle();
      rst = 1'b1; valid = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL rst_busy_stall got=%b exp=0", stall); end
      checks++;
      if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rst_busy_hilo got=%h/%h exp=0/0", hi, lo); end
      $display("reset in busy: stall=%b hi=%h lo=%h", stall, hi, lo);
      m_hi = '0;
      m_lo = '0;
      next_cycle();
      rst = 1'b0;
      run_op("MULTU_3_x_4", F_MULTU, 32'd3, 32'd4);
   endtask

   task automatic test_random();
      logic [5:0]  f;
      logic [31:0] a, b;
      int          sel;
      for (int i = 0; i < 16; i++) begin
`ifdef MULDIV_DIV_EN
         sel = $urandom_range(0, 3);
         f = (sel == 0) ? F_MULT : (sel == 1) ? F_MULTU : (sel == 2) ? F_DIV : F_DIVU;
`else
         sel = $urandom_range(0, 1);
         f = (sel == 0) ? F_MULT : F_MULTU;
`endif
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = $urandom_range(0, 100); b = $urandom_range(1, 9); end
            default: ;
         endcase
         run_op("random", f, a, b);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_mf();
      test_mul_vectors();
      test_mf();
      test_div();
      test_reset_busy();
      test_random();
      test_mf();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/alu_muldiv_ctrl.md
ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 32, giving the datapath width in bits (legal: 8..64, even).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 valid  in  1  the current instruction is live this cycle.
REQ-006 ALUOp  in  2  main-decoder ALU class: 00 add, 01 sub, 10 R-type, 11 add.
REQ-007 funct  in  6  R-type function field.
REQ-008 src_a, src_b  in  WIDTH each  the rs and rt operands.
REQ-009 ALUCtrl  out  4  ALU operation select.
REQ-010 Jr  out  1  the instruction is a JR.
REQ-011 stall  out  1  the PC and the register-file write SHALL be held.
REQ-012 hi, lo  out  WIDTH each  the architectural HI and LO registers.
REQ-013 mf_data  out  WIDTH  MFHI returns hi, MFLO returns lo, otherwise 0.

Function
REQ-014 ALUCtrl SHALL be combinational.
- ALUOp 00/11 -> 0010; ALUOp 01 -> 0110.
- ALUOp 10 decodes funct: 100000/100001 -> 0010, 100010/100011 -> 0110, 100100 -> 0000, 100101 -> 0001, 100110 -> 0011, 100111 -> 1100, 101010 -> 0111, 000000 -> 1000 (SLL), 000010 -> 1001 (SRL), 000011 -> 1010 (SRA).
- Any other funct -> 0010.
REQ-015 Jr SHALL be 1 only when ALUOp=10 and funct=001000.
REQ-016 Mul/div functs SHALL be 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU; MFHI is 010000 and MFLO is 010010.
REQ-017 The FSM SHALL have three states, IDLE, BUSY and DONE, with these transitions:
- IDLE->BUSY on issue, where issue = valid & ALUOp=10 & mul/div funct.
- BUSY->DONE after WIDTH BUSY cycles.
- DONE->IDLE unconditionally.
REQ-018 On issue, the block SHALL capture the operands, the operation and the signedness, and clear an iteration counter of width clog2(WIDTH)+1.
REQ-019 Multiply SHALL be iterative shift-add, one bit per BUSY cycle; divide SHALL be restoring, one quotient bit per BUSY cycle.
REQ-020 Signed operations SHALL run on magnitudes with the signs fixed up at the end:
- the product is negated if the operand signs differ;
- the quotient is negated if the signs differ;
- the remainder takes the dividend's sign.
REQ-021 Results SHALL be written on the edge that ends the last BUSY cycle:
- multiply: hi = upper WIDTH bits of the product, lo = lower WIDTH bits;
- divide: lo = quotient, hi = remainder.
REQ-022 Timing: for an issue in cycle T, stall SHALL be 1 in cycles T..T+WIDTH and 0 in cycle T+WIDTH+1 (DONE); total latency is WIDTH+1 stalled cycles.
REQ-023 In DONE, a valid mul/div instruction (the re-presented held instruction) SHALL NOT re-issue.
REQ-024 While BUSY, mf_data SHALL still reflect the old hi/lo; MFHI/MFLO are held by stall.
REQ-025 A divisor of 0 SHALL give hi = dividend and lo = all ones, with the normal latency.
REQ-026 Signed MIN / -1 SHALL give lo = MIN and hi = 0.
REQ-027 hi/lo SHALL change only as stated in REQ-021.

Reset
REQ-028 While rst=1, the block SHALL hold:
- state = IDLE and the counter at 0;
- hi, lo and the operand registers at 0;
- stall = 0.
REQ-029 Reset during BUSY SHALL abort the operation and leave no partial result in hi/lo.
REQ-030 ALUCtrl and Jr SHALL stay purely combinational, unaffected by reset.

Configuration
REQ-031 Macro MULDIV_DIV_EN SHALL control the divider.
- Defined: DIV and DIVU behave as in REQ-019..REQ-026.
- Undefined: the divider is not instantiated; DIV/DIVU never issue, stall stays 0 and hi/lo are unchanged; MULT/MULTU are unaffected.

Verification (WIDTH=32)
REQ-032 MULTU 0xFFFFFFFF x 0x00000002 -> stall high 33 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; the held instruction in DONE does not re-issue.
REQ-034 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 5 / 0 -> hi=0x00000005, lo=0xFFFFFFFF.
REQ-035 rst pulsed at BUSY cycle 10 -> state IDLE, stall=0, hi=lo=0 immediately; a new MULTU 3x4 then gives lo=12.
REQ-036 Decode sweep:
- ALUOp=10, funct=001000 -> Jr=1;
- funct=101010 -> 0111; funct=000011 -> 1010;
- ALUOp=01 -> 0110.
REQ-037 Build without MULDIV_DIV_EN; DIV 8/2 -> stall=0, hi/lo unchanged.
